fround_arbiter: RTL

- Round-robin scheduler that shares the single float-to-int rounding datapath (fround) among NUM_REQ requesters in the FPU.
- Accepts one rounding request at a time and drives the datapath's enable/operand interface until the datapath asserts ready.
- Returns the result, tagged with the requester index, on a single valid/ready response channel.
- Sits between the AXI-side operation decoder and the fround instance.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/fround_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types: arbiter state encoding, datapath width defaults and
// request/response bundles used by the rounding units.
package fpu_pkg;

  localparam int EXPONENT_WIDTH = 8;
  localparam int FRACTION_WIDTH = 23;
  localparam int OPERAND_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                      sign;
    logic [EXPONENT_WIDTH-1:0] exp;
    logic [FRACTION_WIDTH-1:0] frac;
  } fround_req_t;

  typedef struct packed {
    logic [OPERAND_WIDTH-1:0] int_val;
    logic                     ovf;
    logic                     zero;
    logic                     timeout;
  } fround_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first valid bit strictly above
// last_grant wins, otherwise the search wraps to the lowest valid bit.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int ID_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]        valid,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [N-1:0]        grant,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                grant_any
);

  // Two passes over constant indices: upper region first, then the wrap.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!grant_any && valid[k] && (k > int'(last_grant))) begin
        grant[k]  = 1'b1;
        grant_id  = ID_WIDTH'(k);
        grant_any = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!grant_any && valid[k] && (k <= int'(last_grant))) begin
        grant[k]  = 1'b1;
        grant_id  = ID_WIDTH'(k);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fround_arbiter.sv
// Round-robin front end for the shared float-to-int rounding datapath.
// Optional watchdog on the BUSY wait: define FROUND_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; grant is offered combinationally
// BUSY  | operand driven to the datapath with enable high until ready
// RESP  | result held on the response channel until consumed
module fround_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQ),
  parameter int OPERAND_WIDTH  = fpu_pkg::OPERAND_WIDTH,
  parameter int EXPONENT_WIDTH = fpu_pkg::EXPONENT_WIDTH,
  parameter int FRACTION_WIDTH = fpu_pkg::FRACTION_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                fpu_clk,
  input  logic                                fpu_rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0]                  req_sign_i,
  input  logic [NUM_REQ*EXPONENT_WIDTH-1:0]   req_exp_i,
  input  logic [NUM_REQ*FRACTION_WIDTH-1:0]   req_frac_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [ID_WIDTH-1:0]                 rsp_id_o,
  output logic [OPERAND_WIDTH-1:0]            rsp_int_o,
  output logic                                rsp_overflow_o,
  output logic                                rsp_zero_o,
  output logic                                rsp_timeout_o,
  output logic                                fround_en_o,
  output logic                                fround_sign_o,
  output logic [EXPONENT_WIDTH-1:0]           fround_exp_o,
  output logic [FRACTION_WIDTH-1:0]           fround_frac_o,
  input  logic [OPERAND_WIDTH-1:0]            fround_int_i,
  input  logic                                fround_overflow_i,
  input  logic                                fround_zero_i,
  input  logic                                fround_ready_i
);
  import fpu_pkg::*;

  arb_state_e state_q, state_d;

  logic [NUM_REQ-1:0]        grant;
  logic [ID_WIDTH-1:0]       grant_id;
  logic                      grant_any;
  logic [ID_WIDTH-1:0]       last_grant_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic                      sign_sel, sign_q;
  logic [EXPONENT_WIDTH-1:0] exp_sel, exp_q;
  logic [FRACTION_WIDTH-1:0] frac_sel, frac_q;
  logic [OPERAND_WIDTH-1:0]  int_q;
  logic                      ovf_q, zero_q;
  logic                      expired;

  rr_arbiter #(
    .N        (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .valid      (req_valid_i),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_any  (grant_any)
  );

`ifdef FROUND_ARB_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_WIDTH-1:0] tcnt_q;
  logic                 timeout_q;

  // A ready in the terminal cycle wins over the watchdog.
  assign expired       = (tcnt_q == '0) && !fround_ready_i;
  assign rsp_timeout_o = timeout_q;

  // Down-counter loaded on BUSY entry; terminal count is the last BUSY cycle.
  always_ff @(posedge fpu_clk) begin
    if (!fpu_rst_n) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == IDLE && grant_any) begin
      tcnt_q    <= CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    end else if (state_q == BUSY) begin
      if (fround_ready_i) begin
        timeout_q <= 1'b0;
      end else if (expired) begin
        timeout_q <= 1'b1;
      end else begin
        tcnt_q    <= tcnt_q - 1'b1;
      end
    end
  end
`else
  assign expired       = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  // Operand mux for the requester currently being granted.
  always_comb begin
    sign_sel = 1'b0;
    exp_sel  = '0;
    frac_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sign_sel = req_sign_i[k];
        exp_sel  = req_exp_i[k*EXPONENT_WIDTH +: EXPONENT_WIDTH];
        frac_sel = req_frac_i[k*FRACTION_WIDTH +: FRACTION_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge fpu_clk) begin
    if (!fpu_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state and accept strobe; the strobe is masked while reset is held.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d     = BUSY;
          req_ready_o = fpu_rst_n ? grant : '0;
        end
      end
      BUSY: begin
        if (fround_ready_i || expired) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on grant, result capture on datapath ready or watchdog.
  always_ff @(posedge fpu_clk) begin
    if (!fpu_rst_n) begin
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      id_q         <= '0;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      frac_q       <= '0;
      int_q        <= '0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
    end else if (state_q == IDLE && grant_any) begin
      last_grant_q <= grant_id;
      id_q         <= grant_id;
      sign_q       <= sign_sel;
      exp_q        <= exp_sel;
      frac_q       <= frac_sel;
    end else if (state_q == BUSY && fround_ready_i) begin
      int_q        <= fround_int_i;
      ovf_q        <= fround_overflow_i;
      zero_q       <= fround_zero_i;
    end else if (state_q == BUSY && expired) begin
      int_q        <= '0;
      ovf_q        <= 1'b0;
      zero_q       <= 1'b0;
    end
  end

  assign fround_en_o    = (state_q == BUSY);
  assign fround_sign_o  = sign_q;
  assign fround_exp_o   = exp_q;
  assign fround_frac_o  = frac_q;
  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_id_o       = id_q;
  assign rsp_int_o      = int_q;
  assign rsp_overflow_o = ovf_q;
  assign rsp_zero_o     = zero_q;

endmodule
